// File: rtl/binarization_ctrl.sv
// Frame-level controller for the binarization path: tracks pixel position from the
// sync/DE stream, applies threshold/mode updates only at vsync rises, and checks frame geometry.
module binarization_ctrl #(
    parameter int         H_ACTIVE  = 1280,
    parameter int         V_ACTIVE  = 720,
    parameter int         PIPE_LAT  = 3,
    parameter logic [7:0] THR_RESET = 8'd128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        de_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [7:0]  cfg_threshold,
    input  logic [1:0]  cfg_mode,
    output logic [7:0]  thr_out,
    output logic [1:0]  mode_out,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic        de_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        frame_err
);

    typedef enum logic {
        SEEK  = 1'b0,
        FRAME = 1'b1
    } state_t;

    localparam logic [10:0] H_ACT_C = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_C = 11'(V_ACTIVE);

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    state_t      state_q, state_d;
    logic        vs_d_q, vs_d_d;
    logic        de_d_q, de_d_d;
    logic [10:0] x_cnt_q, x_cnt_d;
    logic [10:0] y_cnt_q, y_cnt_d;
    logic        bad_line_q, bad_line_d;
    logic        frame_err_q, frame_err_d;
    logic        pending_q, pending_d;
    logic [7:0]  shadow_thr_q, shadow_thr_d;
    logic [1:0]  shadow_mode_q, shadow_mode_d;
    logic [7:0]  thr_q, thr_d;
    logic [1:0]  mode_q, mode_d;
    logic [PIPE_LAT-1:0][2:0] sync_q, sync_d;

    logic boundary;
    logic de_fall;

    assign boundary = vsync_in & ~vs_d_q;
    assign de_fall  = de_d_q & ~de_in;

    // Position tracking and geometry check
    always_comb begin
        state_d     = state_q;
        vs_d_d      = vsync_in;
        de_d_d      = de_in;
        x_cnt_d     = x_cnt_q;
        y_cnt_d     = y_cnt_q;
        bad_line_d  = bad_line_q;
        frame_err_d = 1'b0;
        case (state_q)
            SEEK: begin
                x_cnt_d    = '0;
                y_cnt_d    = '0;
                bad_line_d = 1'b0;
                if (boundary) begin
                    state_d = FRAME;
                end
            end
            FRAME: begin
                if (de_fall) begin
                    x_cnt_d = '0;
                    y_cnt_d = sat_inc(y_cnt_q);
                    if (x_cnt_q != H_ACT_C) begin
                        bad_line_d = 1'b1;
                    end
                end else if (de_in) begin
                    x_cnt_d = sat_inc(x_cnt_q);
                end
                // A boundary closes the frame: judge it, then start the next one clean
                if (boundary) begin
                    frame_err_d = bad_line_q || (y_cnt_q != V_ACT_C);
                    y_cnt_d     = '0;
                    bad_line_d  = 1'b0;
                end
            end
            default: state_d = SEEK;
        endcase
    end

    // Config shadow: a transfer landing on a boundary waits for the next one
    always_comb begin
        pending_d     = pending_q;
        shadow_thr_d  = shadow_thr_q;
        shadow_mode_d = shadow_mode_q;
        thr_d         = thr_q;
        mode_d        = mode_q;
        if (boundary && pending_q) begin
            thr_d     = shadow_thr_q;
            mode_d    = shadow_mode_q;
            pending_d = 1'b0;
        end else if (cfg_valid && !pending_q) begin
            shadow_thr_d  = cfg_threshold;
            shadow_mode_d = cfg_mode;
            pending_d     = 1'b1;
        end
    end

    // Sync delay line matching the pixel datapath latency
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = {vsync_in, hsync_in, de_in};
        for (int i = 1; i < PIPE_LAT; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= SEEK;
            vs_d_q        <= 1'b0;
            de_d_q        <= 1'b0;
            x_cnt_q       <= '0;
            y_cnt_q       <= '0;
            bad_line_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            pending_q     <= 1'b0;
            shadow_thr_q  <= '0;
            shadow_mode_q <= '0;
            thr_q         <= THR_RESET;
            mode_q        <= '0;
            sync_q        <= '0;
        end else begin
            state_q       <= state_d;
            vs_d_q        <= vs_d_d;
            de_d_q        <= de_d_d;
            x_cnt_q       <= x_cnt_d;
            y_cnt_q       <= y_cnt_d;
            bad_line_q    <= bad_line_d;
            frame_err_q   <= frame_err_d;
            pending_q     <= pending_d;
            shadow_thr_q  <= shadow_thr_d;
            shadow_mode_q <= shadow_mode_d;
            thr_q         <= thr_d;
            mode_q        <= mode_d;
            sync_q        <= sync_d;
        end
    end

    assign cfg_ready = ~pending_q;
    assign thr_out   = thr_q;
    assign mode_out  = mode_q;
    assign pix_x     = x_cnt_q;
    assign pix_y     = y_cnt_q;
    assign frame_err = frame_err_q;
    assign de_out    = sync_q[PIPE_LAT-1][0];
    assign hsync_out = sync_q[PIPE_LAT-1][1];
    assign vsync_out = sync_q[PIPE_LAT-1][2];

endmodule
